// File: rtl/up_counter_ctrl_pkg.sv
// up_counter_ctrl_pkg: shared state encoding, LED bit map and BCD helper for the counter lab tops
package up_counter_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
    localparam int LED_RUN   = 15;
    localparam int LED_PAUSE = 14;
    localparam int LED_DONE  = 13;
    localparam int BCD_W     = 4;
    // Two-digit BCD increment; callers never step past a valid BCD target, so tens never leaves 0-9.
    function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] v);
        logic [BCD_W-1:0] ones;
        logic [BCD_W-1:0] tens;
        ones = v[BCD_W-1:0];
        tens = v[2*BCD_W-1:BCD_W];
        return (ones == 4'd9) ? {tens + 4'd1, 4'd0} : {tens, ones + 4'd1};
    endfunction
endpackage

// File: rtl/up_counter_ctrl_btn_conditioner.sv
// btn_conditioner: raw button -> 2-FF sync -> debounce -> one-cycle pulse on debounced rising edge
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn_i   : raw asynchronous button level
//   pulse_o : one-cycle pulse, DEB_CYCLES+3 edges after btn_i is first sampled high
module btn_conditioner #(
    parameter int DEB_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic          pulse_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            // Any cycle where the synced level agrees with the accepted level restarts the stability count.
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            deb_prev_q <= deb_q;
            pulse_q    <= deb_q & ~deb_prev_q;
        end
    end
    assign pulse_o = pulse_q;
endmodule

// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl: two-button BCD up-counter (start/pause, reset) counting 00..TARGET, shown on 16 LEDs
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw buttons, [0] start/pause toggle, [1] counter reset
//   led   : [7:0] BCD count, [15] RUN, [14] PAUSE, [13] DONE, [12:8] zero; all zero in IDLE
module up_counter_ctrl
    import up_counter_ctrl_pkg::*;
#(
    parameter int         TICK_DIV   = 4,
    parameter int         DEB_CYCLES = 2,
    parameter logic [7:0] TARGET     = 8'h59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  btn,
    output logic [15:0] led
);
    localparam int TW = $clog2(TICK_DIV + 1);
    logic          start_p;
    logic          rst_p;
    state_t        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   led_q, led_d;
    logic [7:0]    inc;
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk(clk), .rst_n(rst_n), .btn_i(btn[0]), .pulse_o(start_p)
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_reset (
        .clk(clk), .rst_n(rst_n), .btn_i(btn[1]), .pulse_o(rst_p)
    );
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = tick_q;
        inc     = bcd_inc(count_q);
        if (rst_p) begin
            state_d = IDLE;
            count_d = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_p) begin
                        state_d = RUN;
                        tick_d  = '0;
                    end
                end
                RUN: begin
                    if (start_p) begin
                        state_d = PAUSE;
                    end else if (tick_q == TW'(TICK_DIV - 1)) begin
                        tick_d  = '0;
                        count_d = inc;
                        state_d = (inc == TARGET) ? DONE : RUN;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                // Resuming keeps the frozen tick so the interrupted step completes on time.
                PAUSE: state_d = start_p ? RUN : PAUSE;
                default: state_d = state_q;
            endcase
        end
        // LEDs reflect the next state so they change on the same edge as state/count.
        led_d = '0;
        if (state_d != IDLE) begin
            led_d[7:0]       = count_d;
            led_d[LED_RUN]   = (state_d == RUN);
            led_d[LED_PAUSE] = (state_d == PAUSE);
            led_d[LED_DONE]  = (state_d == DONE);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            tick_q  <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
        end
    end
    assign led = led_q;
endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb_up_counter_ctrl: directed scenarios for up_counter_ctrl with TICK_DIV=4, DEB_CYCLES=2, TARGET=8'h12
module tb_up_counter_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  btn = 2'b00;
    logic [15:0] led;
    int          pass_cnt = 0;
    int          total = 0;
    up_counter_ctrl #(.TICK_DIV(4), .DEB_CYCLES(2), .TARGET(8'h12)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .led(led)
    );
    always #5 clk = ~clk;
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        #1;
        total++;
        if (led !== 16'h0000) $display("FAIL reset_t1: led=%h expected 0000", led);
        else pass_cnt++;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 60; i++) begin
            total++;
            if (led !== 16'h0000) $display("FAIL reset_idle[%0d]: led=%h expected 0000", i, led);
            else pass_cnt++;
            cyc(1);
        end
    endtask
    task automatic test_start_rollover;
        btn = 2'b01;
        cyc(5);
        total++;
        if (led[15] !== 1'b0) $display("FAIL start_early: led=%h expected RUN=0", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h8000) $display("FAIL start_run: led=%h expected 8000", led);
        else pass_cnt++;
        cyc(3);
        total++;
        if (led !== 16'h8000) $display("FAIL first_inc_early: led=%h expected 8000", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h8001) $display("FAIL first_inc: led=%h expected 8001", led);
        else pass_cnt++;
        btn = 2'b00;
        cyc(32);
        total++;
        if (led !== 16'h8009) $display("FAIL count_09: led=%h expected 8009", led);
        else pass_cnt++;
        cyc(3);
        total++;
        if (led !== 16'h8009) $display("FAIL count_09_hold: led=%h expected 8009", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h8010) $display("FAIL bcd_rollover: led=%h expected 8010", led);
        else pass_cnt++;
        cyc(7);
        total++;
        if (led !== 16'h8011) $display("FAIL count_11: led=%h expected 8011", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h2012) $display("FAIL done: led=%h expected 2012", led);
        else pass_cnt++;
    endtask
    task automatic test_done;
        cyc(10);
        btn = 2'b01;
        cyc(4);
        btn = 2'b00;
        cyc(10);
        total++;
        if (led !== 16'h2012) $display("FAIL done_ignore_start: led=%h expected 2012", led);
        else pass_cnt++;
        btn = 2'b10;
        cyc(4);
        btn = 2'b00;
        cyc(1);
        total++;
        if (led !== 16'h2012) $display("FAIL done_reset_early: led=%h expected 2012", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h0000) $display("FAIL done_reset: led=%h expected 0000", led);
        else pass_cnt++;
        cyc(10);
    endtask
    task automatic test_glitch;
        btn = 2'b01;
        cyc(1);
        btn = 2'b00;
        cyc(10);
        total++;
        if (led !== 16'h0000) $display("FAIL glitch: led=%h expected 0000", led);
        else pass_cnt++;
    endtask
    task automatic test_pause_resume;
        btn = 2'b01;
        cyc(4);
        btn = 2'b00;
        cyc(11);
        btn = 2'b01;
        cyc(3);
        total++;
        if (led !== 16'h8003) $display("FAIL pre_pause: led=%h expected 8003", led);
        else pass_cnt++;
        cyc(3);
        total++;
        if (led !== 16'h4003) $display("FAIL pause: led=%h expected 4003", led);
        else pass_cnt++;
        cyc(20);
        total++;
        if (led !== 16'h4003) $display("FAIL pause_frozen: led=%h expected 4003", led);
        else pass_cnt++;
        cyc(24);
        btn = 2'b00;
        cyc(5);
        total++;
        if (led !== 16'h4003) $display("FAIL long_hold_one_pulse: led=%h expected 4003", led);
        else pass_cnt++;
        btn = 2'b01;
        cyc(4);
        btn = 2'b00;
        cyc(2);
        total++;
        if (led !== 16'h8003) $display("FAIL resume: led=%h expected 8003", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h8003) $display("FAIL resume_tick3: led=%h expected 8003", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h8004) $display("FAIL resume_partial_tick: led=%h expected 8004", led);
        else pass_cnt++;
    endtask
    task automatic test_priority;
        btn = 2'b11;
        cyc(4);
        btn = 2'b00;
        cyc(1);
        total++;
        if (led !== 16'h8005) $display("FAIL prio_before: led=%h expected 8005", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h0000) $display("FAIL prio_reset: led=%h expected 0000", led);
        else pass_cnt++;
        cyc(10);
        total++;
        if (led !== 16'h0000) $display("FAIL prio_stay_idle: led=%h expected 0000", led);
        else pass_cnt++;
    endtask
    task automatic test_reset_from_pause;
        btn = 2'b01;
        cyc(4);
        btn = 2'b00;
        cyc(25);
        btn = 2'b01;
        cyc(4);
        btn = 2'b00;
        cyc(2);
        total++;
        if (led !== 16'h4007) $display("FAIL pause_07: led=%h expected 4007", led);
        else pass_cnt++;
        cyc(5);
        btn = 2'b10;
        cyc(4);
        btn = 2'b00;
        cyc(1);
        total++;
        if (led !== 16'h4007) $display("FAIL pause_reset_early: led=%h expected 4007", led);
        else pass_cnt++;
        cyc(1);
        total++;
        if (led !== 16'h0000) $display("FAIL pause_reset: led=%h expected 0000", led);
        else pass_cnt++;
        cyc(4);
        btn = 2'b01;
        cyc(4);
        btn = 2'b00;
        cyc(2);
        total++;
        if (led !== 16'h8000) $display("FAIL restart_00: led=%h expected 8000", led);
        else pass_cnt++;
        cyc(4);
        total++;
        if (led !== 16'h8001) $display("FAIL restart_01: led=%h expected 8001", led);
        else pass_cnt++;
    endtask
    task automatic test_async_reset;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (led !== 16'h0000) $display("FAIL async_reset: led=%h expected 0000", led);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        cyc(5);
        total++;
        if (led !== 16'h0000) $display("FAIL async_reset_idle: led=%h expected 0000", led);
        else pass_cnt++;
    endtask
    initial begin
        test_reset();
        test_start_rollover();
        test_done();
        test_glitch();
        test_pause_resume();
        test_priority();
        test_reset_from_pause();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
